write8to32: RTL and testbench

WRITE8TO32 -- requirements
Module: write8to32

---
 rtl/write8to32_if.sv | 25 ++
 rtl/write8to32.sv | 162 ++++++++++++++++
 tb/tb_write8to32.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/write8to32_if.sv
// Byte-in / word-out bus bundle for write8to32: command, byte stream, word write
// port and completion flag. The master modport is the environment, slave the packer.
interface write8to32_if;
  logic               _start;
  logic signed [31:0] base;
  logic signed [31:0] count;
  logic [7:0]         in_data;
  logic               in_valid;
  logic               in_ready;
  logic [31:0]        wr_addr;
  logic [31:0]        wr_data;
  logic               wr_valid;
  logic               wr_ready;
  logic               _done;

  modport master (
    output _start, base, count, in_data, in_valid, wr_ready,
    input  in_ready, wr_addr, wr_data, wr_valid, _done
  );

  modport slave (
    input  _start, base, count, in_data, in_valid, wr_ready,
    output in_ready, wr_addr, wr_data, wr_valid, _done
  );
endinterface

// File: rtl/write8to32.sv
// Packs a byte stream into count 32-bit words written to base, base+4, ...
// Define WRITE8TO32_BIG_ENDIAN_EN to place the first byte in the MSB instead of the LSB.
module write8to32 (
  input logic          _clock,
  input logic          _reset,
  write8to32_if.slave  bus
);
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    WRITE   = 2'd2,
    DONE    = 2'd3
  } state_t;

  state_t             state_r, state_s;
  logic signed [31:0] base_r, base_s;
  logic signed [31:0] count_r, count_s;
  logic [31:0]        i_r, i_s;
  logic [1:0]         j_r, j_s;
  logic [31:0]        word_r, word_s;
  logic [31:0]        packed_s;
  logic [31:0]        wr_addr_r, wr_addr_s;
  logic [31:0]        wr_data_r, wr_data_s;
  logic               in_ready_r, in_ready_s;
  logic               wr_valid_r, wr_valid_s;
  logic               done_r, done_s;

  function automatic logic [31:0] pack_byte(input logic [31:0] word,
                                            input logic [1:0]  lane,
                                            input logic [7:0]  data);
    logic [31:0] res;
    res = word;
`ifdef WRITE8TO32_BIG_ENDIAN_EN
    res[{~lane, 3'b000} +: 8] = data;
`else
    res[{lane, 3'b000} +: 8] = data;
`endif
    return res;
  endfunction

  // Next-state and next-output logic; _start overrides every state.
  always_comb begin
    state_s    = state_r;
    base_s     = base_r;
    count_s    = count_r;
    i_s        = i_r;
    j_s        = j_r;
    word_s     = word_r;
    wr_addr_s  = wr_addr_r;
    wr_data_s  = wr_data_r;
    in_ready_s = in_ready_r;
    wr_valid_s = wr_valid_r;
    done_s     = done_r;
    packed_s   = pack_byte(word_r, j_r, bus.in_data);

    if (bus._start) begin
      base_s     = bus.base;
      count_s    = bus.count;
      i_s        = 32'd0;
      j_s        = 2'd0;
      word_s     = 32'd0;
      wr_valid_s = 1'b0;
      if (bus.count > 32'sd0) begin
        state_s    = COLLECT;
        in_ready_s = 1'b1;
        done_s     = 1'b0;
      end else begin
        state_s    = DONE;
        in_ready_s = 1'b0;
        done_s     = 1'b1;
      end
    end else begin
      case (state_r)
        IDLE: begin
          in_ready_s = 1'b0;
          wr_valid_s = 1'b0;
          done_s     = 1'b0;
        end
        COLLECT: begin
          if (bus.in_valid && in_ready_r) begin
            if (j_r == 2'd3) begin
              state_s    = WRITE;
              wr_valid_s = 1'b1;
              wr_data_s  = packed_s;
              wr_addr_s  = base_r + (i_r << 2'd2);
              in_ready_s = 1'b0;
              j_s        = 2'd0;
              word_s     = 32'd0;
            end else begin
              j_s    = j_r + 2'd1;
              word_s = packed_s;
            end
          end else begin
            word_s = word_r;
          end
        end
        WRITE: begin
          if (bus.wr_ready) begin
            wr_valid_s = 1'b0;
            i_s        = i_r + 32'd1;
            // count is known positive here, so an unsigned compare is exact
            if ((i_r + 32'd1) < $unsigned(count_r)) begin
              state_s    = COLLECT;
              in_ready_s = 1'b1;
            end else begin
              state_s = DONE;
              done_s  = 1'b1;
            end
          end else begin
            wr_valid_s = 1'b1;
          end
        end
        DONE: begin
          in_ready_s = 1'b0;
          wr_valid_s = 1'b0;
          done_s     = 1'b1;
        end
        default: begin
          state_s    = IDLE;
          in_ready_s = 1'b0;
          wr_valid_s = 1'b0;
          done_s     = 1'b0;
        end
      endcase
    end
  end

  // State and output registers with asynchronous clear.
  always_ff @(posedge _clock or negedge _reset) begin
    if (!_reset) begin
      state_r    <= IDLE;
      base_r     <= 32'sd0;
      count_r    <= 32'sd0;
      i_r        <= 32'd0;
      j_r        <= 2'd0;
      word_r     <= 32'd0;
      wr_addr_r  <= 32'd0;
      wr_data_r  <= 32'd0;
      in_ready_r <= 1'b0;
      wr_valid_r <= 1'b0;
      done_r     <= 1'b0;
    end else begin
      state_r    <= state_s;
      base_r     <= base_s;
      count_r    <= count_s;
      i_r        <= i_s;
      j_r        <= j_s;
      word_r     <= word_s;
      wr_addr_r  <= wr_addr_s;
      wr_data_r  <= wr_data_s;
      in_ready_r <= in_ready_s;
      wr_valid_r <= wr_valid_s;
      done_r     <= done_s;
    end
  end

  assign bus.in_ready = in_ready_r;
  assign bus.wr_valid = wr_valid_r;
  assign bus.wr_addr  = wr_addr_r;
  assign bus.wr_data  = wr_data_r;
  assign bus._done    = done_r;
endmodule

// File: tb/tb_write8to32.sv
// Directed bench for write8to32: packing, stalls, empty/negative counts,
// address wrap, restart mid-transfer and asynchronous reset mid-write.
module tb_write8to32;
  logic clock;
  logic reset;
  int   total;
  int   bad;

  write8to32_if bus();

  write8to32 dut (
    ._clock (clock),
    ._reset (reset),
    .bus    (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Bytes are listed first-in at [7:0]; big-endian packing reverses them.
  function automatic logic [31:0] exp_word(input logic [31:0] le);
`ifdef WRITE8TO32_BIG_ENDIAN_EN
    return {le[7:0], le[15:8], le[23:16], le[31:24]};
`else
    return le;
`endif
  endfunction

  task automatic do_start(input logic [31:0] b, input logic [31:0] c);
    bus._start = 1'b1;
    bus.base   = b;
    bus.count  = c;
    @(negedge clock);
    bus._start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] d);
    int n = 0;
    while (!bus.in_ready && n < 20) begin
      @(negedge clock);
      n++;
    end
    if (!bus.in_ready) begin
      check_val("in_ready_wait", 32'(bus.in_ready), 32'd1);
    end else begin
      bus.in_valid = 1'b1;
      bus.in_data  = d;
      @(negedge clock);
      bus.in_valid = 1'b0;
    end
  endtask

  task automatic send_word(input logic [31:0] le);
    for (int b = 0; b < 4; b++) send_byte(le[8*b +: 8]);
  endtask

  task automatic take_write(input string tag, input logic [31:0] addr,
                            input logic [31:0] data, input int stalls);
    check_val({tag, "_lat"}, 32'(bus.wr_valid), 32'd1);
    for (int k = 0; k <= stalls; k++) begin
      check_val({tag, "_valid"}, 32'(bus.wr_valid), 32'd1);
      check_val({tag, "_addr"}, bus.wr_addr, addr);
      check_val({tag, "_data"}, bus.wr_data, data);
      check_val({tag, "_inrdy"}, 32'(bus.in_ready), 32'd0);
      if (k == stalls) bus.wr_ready = 1'b1;
      @(negedge clock);
    end
    check_val({tag, "_drop"}, 32'(bus.wr_valid), 32'd0);
  endtask

  task automatic xfer_word(input string tag, input logic [31:0] le,
                           input logic [31:0] addr, input int stalls);
    bus.wr_ready = (stalls == 0) ? 1'b1 : 1'b0;
    send_word(le);
    take_write(tag, addr, exp_word(le), stalls);
  endtask

  task automatic check_done(input string tag);
    check_val({tag, "_done"}, 32'(bus._done), 32'd1);
    check_val({tag, "_inrdy"}, 32'(bus.in_ready), 32'd0);
    check_val({tag, "_wrv"}, 32'(bus.wr_valid), 32'd0);
  endtask

  task automatic pulse_reset();
    reset = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
  endtask

  task automatic empty_count(input string tag, input logic [31:0] c);
    pulse_reset();
    check_val({tag, "_pre"}, 32'(bus._done), 32'd0);
    do_start(32'h0000_0100, c);
    check_done(tag);
    for (int k = 0; k < 3; k++) begin
      @(negedge clock);
      check_val({tag, "_nowr"}, 32'(bus.wr_valid), 32'd0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    total        = 0;
    bad          = 0;
    reset        = 1'b0;
    bus._start   = 1'b0;
    bus.base     = 32'sd0;
    bus.count    = 32'sd0;
    bus.in_data  = 8'd0;
    bus.in_valid = 1'b0;
    bus.wr_ready = 1'b0;

    // Reset state, then idle must ignore traffic until _start
    #12;
    check_val("rst_inrdy", 32'(bus.in_ready), 32'd0);
    check_val("rst_wrv", 32'(bus.wr_valid), 32'd0);
    check_val("rst_done", 32'(bus._done), 32'd0);
    check_val("rst_addr", bus.wr_addr, 32'd0);
    check_val("rst_data", bus.wr_data, 32'd0);
    @(negedge clock);
    reset        = 1'b1;
    bus.in_valid = 1'b1;
    bus.wr_ready = 1'b1;
    repeat (2) @(negedge clock);
    check_val("idle_inrdy", 32'(bus.in_ready), 32'd0);
    check_val("idle_wrv", 32'(bus.wr_valid), 32'd0);
    check_val("idle_done", 32'(bus._done), 32'd0);
    bus.in_valid = 1'b0;

    // Two words, memory always ready
    do_start(32'h0000_0100, 32'd2);
    check_val("t1_inrdy", 32'(bus.in_ready), 32'd1);
    xfer_word("t1w0", 32'h4433_2211, 32'h0000_0100, 0);
    check_val("t1_mid_inrdy", 32'(bus.in_ready), 32'd1);
    xfer_word("t1w1", 32'h8877_6655, 32'h0000_0104, 0);
    check_done("t1");
    repeat (3) @(negedge clock);
    check_done("t1_hold");

    // Same transfer with the first write stalled three cycles
    do_start(32'h0000_0100, 32'd2);
    xfer_word("t2w0", 32'h4433_2211, 32'h0000_0100, 3);
    xfer_word("t2w1", 32'h8877_6655, 32'h0000_0104, 0);
    check_done("t2");

    // Zero and negative counts
    empty_count("c0", 32'd0);
    empty_count("cneg", 32'hFFFF_FFFB);

    // Address wraps past the top of the space
    do_start(32'hFFFF_FFFC, 32'd2);
    xfer_word("wrap0", 32'h0403_0201, 32'hFFFF_FFFC, 0);
    xfer_word("wrap1", 32'h0807_0605, 32'h0000_0000, 0);
    check_done("wrap");

    // Restart after two bytes discards the partial word
    do_start(32'h0000_0300, 32'd2);
    send_byte(8'hAA);
    send_byte(8'hBB);
    do_start(32'h0000_0200, 32'd1);
    check_val("ab_inrdy", 32'(bus.in_ready), 32'd1);
    xfer_word("ab", 32'h0D0C_0B0A, 32'h0000_0200, 0);
    check_done("ab");

    // Restart while a write is pending drops that write
    do_start(32'h0000_0400, 32'd1);
    bus.wr_ready = 1'b0;
    send_word(32'h1111_1111);
    check_val("rw_pend", 32'(bus.wr_valid), 32'd1);
    do_start(32'h0000_0500, 32'd1);
    check_val("rw_wrv", 32'(bus.wr_valid), 32'd0);
    check_val("rw_inrdy", 32'(bus.in_ready), 32'd1);
    xfer_word("rw", 32'h2222_2222, 32'h0000_0500, 0);
    check_done("rw");

    // Asynchronous reset in the middle of a stalled write
    do_start(32'h0000_0600, 32'd1);
    bus.wr_ready = 1'b0;
    send_word(32'h3333_3333);
    check_val("ar_pend", 32'(bus.wr_valid), 32'd1);
    #2;
    reset = 1'b0;
    #1;
    check_val("ar_wrv", 32'(bus.wr_valid), 32'd0);
    check_val("ar_done", 32'(bus._done), 32'd0);
    check_val("ar_addr", bus.wr_addr, 32'd0);
    @(negedge clock);
    reset        = 1'b1;
    bus.wr_ready = 1'b1;
    bus.in_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clock);
      check_val("ar_post_wrv", 32'(bus.wr_valid), 32'd0);
      check_val("ar_post_inrdy", 32'(bus.in_ready), 32'd0);
      check_val("ar_post_done", 32'(bus._done), 32'd0);
    end
    bus.in_valid = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
